serial_rx_module: RTL and testbench
===================================

# serial_rx_module

Receive side of the board's serial link. It deserialises 8N1 UART frames arriving on a single input pin into bytes and reports framing errors. Any ASCII scale command '1'–'5' (8'h31–8'h35) is decoded into the 3-bit `scale` value consumed by `key_module`. It sits beside `screen_module`, which drives the transmit direction, and replaces the hard-coded scale table in the top level.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. Derived values:
  - `DIV` = CLK_HZ/BAUD, integer division (5208).
  - `HALF` = DIV/2 (2604).
  - Counter width is `$clog2(DIV)`.
- `clk` input, 1 bit: system clock, all logic on its rising edge.
- `reset_n` input, 1 bit: synchronous, active-high reset. Asserted (1) means reset.
- `rxd` input, 1 bit: asynchronous serial line. Idles high.
- `data` output, 8 bits: last good byte received. Holds its value between frames.
- `valid` output, 1 bit: one-cycle pulse when `data` updates.
- `frame_err` output, 1 bit: one-cycle pulse when a stop bit samples 0.
- `scale` output, 3 bits: current scale, range 1–5.
- `scale_upd` output, 1 bit: one-cycle pulse when `scale` is written.

## Operation
- `rxd` passes through a 2-flop synchroniser to give `rx_s`. All decisions use `rx_s`.
- FSM states are IDLE, START, DATA, STOP and BREAK. There is one baud counter `cnt` and a 3-bit bit index `bidx`.
- IDLE: `cnt`=0. When `rx_s`==0, go to START.
- START: count up. When `cnt`==HALF-1:
  - if `rx_s`==0 (start bit confirmed at mid-bit), go to DATA with `cnt`=0 and `bidx`=0;
  - otherwise (glitch), go to IDLE with no output.
- DATA: when `cnt`==DIV-1:
  - shift `rx_s` into the shift register LSB-first and set `cnt`=0;
  - after `bidx`==7, go to STOP; otherwise increment `bidx`.
- STOP: when `cnt`==DIV-1:
  - if `rx_s`==1, load `data` from the shift register, pulse `valid` and go to IDLE;
  - if `rx_s`==0, pulse `frame_err`, leave `data` unchanged and go to BREAK.
- BREAK: stay until `rx_s`==1, then go to IDLE. A held-low line therefore produces exactly one `frame_err` and no spurious frames.
- Scale decode happens in the cycle after `valid`:
  - if `data` is in 8'h31–8'h35, `scale` <= `data`[2:0] and `scale_upd` pulses;
  - all other bytes leave `scale` unchanged with no pulse;
  - a byte equal to the current scale still pulses `scale_upd`.
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `scale`=3'd1, `scale_upd`=0.
- Reset internal state: FSM in IDLE, `cnt`=0, `bidx`=0, shift register 0, both synchroniser flops 1.
- Reset asserted mid-frame abandons the frame. After release the block waits in IDLE for a new falling edge; a line that is still low is taken as a start bit and resolved by the START/STOP checks.

## Timing
- Synchroniser latency is 2 cycles.
- Let T0 be the first clock edge that samples `rxd` low.
  - Start-bit check happens at T0+2+HALF (±1).
  - Data bit k is sampled at T0+2+HALF+(k+1)·DIV.
  - `valid` or `frame_err` is high during cycle T0+2+HALF+9·DIV+1 (±1).
  - `scale_upd` and the new `scale` appear exactly 1 cycle after `valid`.
- `valid` and `frame_err` are never high in the same cycle. Each is exactly one cycle wide.
- Back-to-back frames: a start edge that arrives during the stop bit's second half is detected in the cycle after STOP exits, so no frames are lost at full line rate.
- Tolerates ±2% baud mismatch. Each sample lands within 0.5 bit of centre over 10 bits.

## Test plan
- Reset, then idle line for 100 cycles:
  - all outputs at reset values, `scale`=1;
  - `valid`, `frame_err` and `scale_upd` never pulse.
- Send 8'h33 at 9600 baud:
  - `valid` pulses once, within ±2 cycles of T0+2+2604+9·5208+1;
  - `data`=8'h33;
  - next cycle `scale`=3 and `scale_upd` pulses.
- Send 8'h41 then 8'h36 back-to-back:
  - two `valid` pulses with `data`=8'h41, then `data`=8'h36;
  - `scale` stays 3 and `scale_upd` does not pulse.
- Send a frame 8'h35 with stop bit forced 0, then hold `rxd` low for 3 bit times, then release:
  - exactly one `frame_err` pulse;
  - no `valid` pulse, `data` unchanged, `scale` unchanged;
  - a following good 8'h32 gives `scale`=2.
- Drive a 1000-cycle low glitch on an idle line:
  - FSM returns to IDLE;
  - no `valid` or `frame_err` pulse.
- Assert `reset_n` for 1 cycle in the middle of DATA for 8'h34, then send 8'h31:
  - no output for the aborted frame;
  - `scale` reset to 1;
  - 8'h31 decodes normally with `valid` and `scale_upd` pulses.

Source files
------------

// File: rtl/serial_rx_module.sv
// 8N1 UART receiver: deserialises rxd into bytes, flags bad stop bits and
// decodes ASCII '1'..'5' into the 3-bit scale setting.
module serial_rx_module #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic [2:0] scale,
  output logic       scale_upd,
  output logic [2:0] state_dbg
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n;
  logic          frame_err_n;
  logic          rx_meta, rx_s;
  logic          scale_hit;

  // Output strobes: valid, frame_err and scale_upd are single-cycle pulses with
  // no back-pressure; data and scale are held until the next pulse rewrites them.

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bidx_n      = bidx;
    shreg_n     = shreg;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        // Half-bit wait puts every later sample near bit centre.
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = S_DATA;
            bidx_n  = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == DIV_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (bidx == 3'd7) state_n = S_STOP;
          else              bidx_n  = bidx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_BREAK: begin
        // A held-low line reports once, then waits for the line to recover.
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    scale_hit = valid && (data >= 8'h31) && (data <= 8'h35);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      scale     <= 3'd1;
      scale_upd <= 1'b0;
    end else begin
      scale_upd <= scale_hit;
      if (scale_hit) scale <= data[2:0];
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_serial_rx_module.sv
// Directed bench for serial_rx_module at a reduced clock/baud ratio (DIV=32)
// with a queue-based scoreboard fed by the driver and drained by a monitor.
module tb_serial_rx_module;

  localparam int CLK_HZ = 320;
  localparam int BAUD   = 10;
  localparam int DIV    = 32;
  localparam int HALF   = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic [2:0] scale;
  logic       scale_upd;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  bit lat_check = 1'b0;
  logic prev_valid = 1'b0;
  int ferr_pending = 0;
  int ferr_seen = 0;

  logic [7:0] exp_q[$];
  logic [2:0] exp_scale_q[$];

  serial_rx_module #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .scale     (scale),
    .scale_upd (scale_upd),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: one 8N1 frame, optional one-cycle reset pulse after abort_at cycles
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int abort_at);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * DIV; i++) begin
      rxd = fr[i / DIV];
      if (i == 0) t0 = cyc + 1;
      @(negedge clk);
      if (i == abort_at) begin
        reset_n = 1'b1;
        rxd     = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    if (b >= 8'h31 && b <= 8'h35) exp_scale_q.push_back(b[2:0]);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (valid || frame_err) check("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %0h expected no valid (cycle %0d)", data, cyc);
      end else begin
        check("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
      if (lat_check) begin
        lat_check = 1'b0;
        checks++;
        if (cyc < t0 + 2 + HALF + 9 * DIV + 1 - 2 || cyc > t0 + 2 + HALF + 9 * DIV + 1 + 2) begin
          errors++;
          $display("FAIL valid_latency: got cycle %0d expected %0d +-2", cyc - t0,
                   2 + HALF + 9 * DIV + 1);
        end
      end
    end
    if (frame_err) begin
      ferr_seen++;
      checks++;
      if (ferr_pending == 0) begin
        errors++;
        $display("FAIL unexpected_frame_err: got pulse expected none (cycle %0d)", cyc);
      end else begin
        ferr_pending--;
      end
    end
    if (scale_upd) begin
      check("upd_follows_valid", {31'd0, prev_valid}, 32'd1);
      if (exp_scale_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_scale_upd: got scale %0d expected no update (cycle %0d)", scale, cyc);
      end else begin
        check("scale", {29'd0, scale}, {29'd0, exp_scale_q.pop_front()});
      end
    end
    prev_valid = valid;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_scale", {29'd0, scale}, 32'd1);
    check("rst_scale_upd", {31'd0, scale_upd}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    reset_n = 1'b0;
    idle(100);
    check("idle_scale", {29'd0, scale}, 32'd1);
    check("idle_data", {24'd0, data}, 32'h00);

    // single command byte, with latency check
    expect_byte(8'h33);
    lat_check = 1'b1;
    drive_frame(8'h33, 1'b1, -1);
    idle(2 * DIV);
    check("scale_after_33", {29'd0, scale}, 32'd3);

    // back-to-back non-command bytes
    expect_byte(8'h41);
    expect_byte(8'h36);
    drive_frame(8'h41, 1'b1, -1);
    drive_frame(8'h36, 1'b1, -1);
    idle(2 * DIV);
    check("scale_kept_3", {29'd0, scale}, 32'd3);
    check("data_36", {24'd0, data}, 32'h36);

    // bad stop bit, then line held low for three bit times
    ferr_pending++;
    drive_frame(8'h35, 1'b0, -1);
    rxd = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    idle(2 * DIV);
    check("ferr_count", ferr_seen, 32'd1);
    check("data_kept_after_ferr", {24'd0, data}, 32'h36);
    check("scale_kept_after_ferr", {29'd0, scale}, 32'd3);
    check("state_idle_after_break", {29'd0, state_dbg}, 32'd0);
    expect_byte(8'h32);
    drive_frame(8'h32, 1'b1, -1);
    idle(2 * DIV);
    check("scale_after_32", {29'd0, scale}, 32'd2);

    // short low glitch shorter than half a bit
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    idle(DIV);
    check("state_idle_after_glitch", {29'd0, state_dbg}, 32'd0);

    // reset mid-DATA of 8'h34; transmitter stops with the link reset
    drive_frame(8'h34, 1'b1, 3 * DIV + DIV / 2);
    check("scale_after_reset", {29'd0, scale}, 32'd1);
    check("data_after_reset", {24'd0, data}, 32'h00);
    check("state_after_reset", {29'd0, state_dbg}, 32'd0);
    idle(4 * DIV);
    expect_byte(8'h31);
    drive_frame(8'h31, 1'b1, -1);
    idle(2 * DIV);
    check("scale_after_31", {29'd0, scale}, 32'd1);
    check("data_31", {24'd0, data}, 32'h31);

    // drain, bounded
    for (int i = 0; i < 20 * DIV; i++) begin
      if (exp_q.size() == 0 && exp_scale_q.size() == 0) break;
      @(negedge clk);
    end
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("scale_q_drained", exp_scale_q.size(), 32'd0);
    check("ferr_pending_zero", ferr_pending, 32'd0);
    check("ferr_total", ferr_seen, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
